qos_flow_arbiter: RTL and testbench
===================================

# qos_flow_arbiter

Read-side scheduler for the QoS module's four virtual-channel FIFOs. It consumes the per-FIFO pause/continue strobes and the `error_full` flags produced by the QoS control FSM, and keeps a paused mask per FIFO. It arbitrates among FIFOs that are non-empty and not paused, pops one word at a time, and presents that word on a valid/ready output toward the link egress.

## Interface
- `DATA_W`, 6: word width of each FIFO and of the output.
- `NUM_FIFOS`, 4: number of FIFOs. Fixed at 4; all per-FIFO vectors are 4 bits.
- `CLK  in  1`: clock, all logic on the rising edge.
- `reset_L  in  1`: one clock; reset is asynchronous and active-low.
- `init  in  1`: synchronous soft clear from the control FSM.
- `pause_stb  in  4`: one-cycle pause strobe per FIFO.
- `continue_stb  in  4`: one-cycle continue strobe per FIFO.
- `error_full  in  4`: overflow error flags; any bit set halts new pops.
- `empty  in  4`: FIFO empty flags.
- `fifo_data  in  4*DATA_W`: FIFO read data. FIFO i occupies bits [i*DATA_W +: DATA_W]. Data is valid the cycle after `pop[i]`.
- `pop  out  4`: one-hot read enable, registered.
- `out_data  out  DATA_W`: output word.
- `out_valid  out  1`: output word valid.
- `out_ready  in  1`: downstream accepts the word when `out_valid & out_ready`.
- `paused  out  4`: current paused mask (status).
- `halted  out  1`: high while `|error_full`.

## Operation
- Paused mask, per bit i:
  - `pause_stb[i]` sets it; `continue_stb[i]` clears it.
  - If both strobes are high in the same cycle, pause wins.
  - `init` clears the whole mask.
- Eligible set = `~empty & ~paused`. Pause and continue strobes take effect for arbitration on the cycle after they arrive.
- State machine:
  - **S_ARB**: if not halted and the eligible set is non-zero, assert `pop[g]` for the granted FIFO g and go to S_READ. Otherwise stay.
  - **S_READ**: load `fifo_data[g]` into `out_data`, set `out_valid`, go to S_HOLD.
  - **S_HOLD**: hold the word while `out_ready` is low.
    - On accept, if the eligible set is non-zero and not halted, pop the next grant and go to S_READ (`out_valid` falls in that same cycle).
    - On accept otherwise, go to S_ARB.
- Grant is round-robin: search starts at `last_grant+1` modulo 4, and `last_grant` updates on each pop.
- A pause or `error_full` arriving while a word is in S_READ or S_HOLD does not cancel that word; it completes normally.
- `init` in any state:
  - next state S_ARB;
  - `out_valid` = 0;
  - `pop` = 0;
  - `last_grant` = 3.
- Reset values: `pop`=0, `out_valid`=0, `out_data`=0, `paused`=0, `halted`=0, state S_ARB, `last_grant`=3 (FIFO0 is granted first).
- Never pop a FIFO whose `empty` bit is set in the same cycle as the pop.

## Timing
- `pop` is registered.
- First word latency: eligible at cycle N → `pop` high in N+1 → `out_valid` high in N+2.
- Sustained throughput: one word per 2 cycles with `out_ready` held high.
- `out_data` is stable while `out_valid & ~out_ready`.
- `halted` is a registered copy of `|error_full` (1-cycle delay). It blocks pops from the cycle after it rises.

## Configuration
- `QOS_ARB_STRICT_PRIO_EN`:
  - **Defined**: fixed priority, FIFO0 highest and FIFO3 lowest; `last_grant` is unused.
  - **Undefined (default)**: round-robin as described above.

## Structure
- Package `qos_pkg` holds:
  - `NUM_FIFOS`;
  - default `DATA_W`;
  - state encoding constants S_ARB=2'd0, S_READ=2'd1, S_HOLD=2'd2.
- One sub-module, `qos_rr_picker`: combinational one-hot grant from the eligible mask and `last_grant`, including the strict-priority variant under the macro.

## Test plan
1. **Round-robin order**: reset, `empty`=4'b0000, `out_ready`=1 → pops in order 0, 1, 2, 3, 0; each `out_data` matches the corresponding FIFO word.
2. **Pause and continue**: `pause_stb`=4'b0010 for one cycle → FIFO1 is skipped (order 0, 2, 3, 0) and `paused`=4'b0010. Then `continue_stb`=4'b0010 → FIFO1 is granted again.
3. **Simultaneous strobes**: `pause_stb`=`continue_stb`=4'b0100 in the same cycle → `paused[2]`=1.
4. **Backpressure**: hold `out_ready`=0 for 5 cycles with a word in S_HOLD → `out_data` and `out_valid` stay constant and `pop` stays 0. Release `out_ready` → the next pop occurs in that same cycle.
5. **Error halt**: `error_full`=4'b1000 raised during S_HOLD → the current word completes, then no pops occur and `halted`=1. Clear `error_full` → arbitration resumes.
6. **Init mid-transfer**: pulse `init` in S_READ → next cycle `out_valid`=0 and `paused`=0; the following grant goes to FIFO0.

Source files
------------

// File: rtl/qos_flow_arbiter_pkg.sv
// Shared constants and state encoding for the QoS read-side flow arbiter.
// Strict-priority grant is selected by defining QOS_ARB_STRICT_PRIO_EN.
package qos_pkg;
  localparam int NUM_FIFOS = 4;
  localparam int DATA_W    = 6;

  typedef enum logic [1:0] {
    S_ARB  = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/qos_rr_picker.sv
// Combinational one-hot grant over the eligible mask.
// Round-robin from last_grant+1 by default; fixed priority (FIFO0 first) under QOS_ARB_STRICT_PRIO_EN.
module qos_rr_picker
  import qos_pkg::*;
(
  input  logic [NUM_FIFOS-1:0] i_eligible,
  input  logic [1:0]           i_last_grant,
  output logic [NUM_FIFOS-1:0] o_grant,
  output logic [1:0]           o_grant_idx
);

`ifdef QOS_ARB_STRICT_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = ^i_last_grant;

  // Scan from lowest priority upward so the highest-priority eligible FIFO wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
      if (i_eligible[k]) begin
        o_grant     = '0;
        o_grant[k]  = 1'b1;
        o_grant_idx = 2'(k);
      end
    end
  end
`else
  logic       w_found;
  logic [1:0] w_idx;

  // The 2-bit index wraps naturally, giving the modulo-4 search order.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      w_idx = i_last_grant + 2'(k);
      if (!w_found && i_eligible[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end
`endif

endmodule

// File: rtl/qos_flow_arbiter.sv
// Read-side scheduler for four virtual-channel FIFOs: pause mask, error halt, arbitration and valid/ready egress.
// Grant policy selected by QOS_ARB_STRICT_PRIO_EN (see qos_rr_picker).
module qos_flow_arbiter #(
  parameter int DATA_W = qos_pkg::DATA_W
) (
  input  logic                                 CLK,
  input  logic                                 reset_L,
  input  logic                                 init,
  input  logic [qos_pkg::NUM_FIFOS-1:0]        pause_stb,
  input  logic [qos_pkg::NUM_FIFOS-1:0]        continue_stb,
  input  logic [qos_pkg::NUM_FIFOS-1:0]        error_full,
  input  logic [qos_pkg::NUM_FIFOS-1:0]        empty,
  input  logic [qos_pkg::NUM_FIFOS*DATA_W-1:0] fifo_data,
  output logic [qos_pkg::NUM_FIFOS-1:0]        pop,
  output logic [DATA_W-1:0]                    out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [qos_pkg::NUM_FIFOS-1:0]        paused,
  output logic                                 halted
);
  import qos_pkg::*;

  state_t                r_state, w_state_next;
  logic [NUM_FIFOS-1:0]  r_pop, w_pop_next;
  logic [NUM_FIFOS-1:0]  r_paused;
  logic [NUM_FIFOS-1:0]  w_eligible, w_grant;
  logic [1:0]            r_last_grant, w_last_grant_next, w_grant_idx;
  logic [DATA_W-1:0]     r_out_data, w_out_data_next, w_read_word;
  logic                  r_out_valid, w_out_valid_next;
  logic                  r_halted, w_can_pop;
  logic [DATA_W-1:0]     w_masked [NUM_FIFOS];

  assign w_eligible = ~empty & ~r_paused;
  assign w_can_pop  = ~r_halted & (|w_eligible);

  qos_rr_picker u_picker (
    .i_eligible   (w_eligible),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  // The FIFO being read is the one whose pop is high during S_READ.
  for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_rd_mux
    assign w_masked[gi] = fifo_data[gi*DATA_W +: DATA_W] & {DATA_W{r_pop[gi]}};
  end
  assign w_read_word = w_masked[0] | w_masked[1] | w_masked[2] | w_masked[3];

  always_ff @(posedge CLK or negedge reset_L) begin
    if (!reset_L) begin
      r_paused <= '0;
      r_halted <= 1'b0;
    end else begin
      r_paused <= init ? '0 : ((r_paused & ~continue_stb) | pause_stb);
      r_halted <= |error_full;
    end
  end

  always_ff @(posedge CLK or negedge reset_L) begin
    if (!reset_L) begin
      r_state      <= S_ARB;
      r_pop        <= '0;
      r_last_grant <= 2'd3;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pop        <= w_pop_next;
      r_last_grant <= w_last_grant_next;
      r_out_data   <= w_out_data_next;
      r_out_valid  <= w_out_valid_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pop_next        = '0;
    w_last_grant_next = r_last_grant;
    w_out_data_next   = r_out_data;
    w_out_valid_next  = r_out_valid;
    case (r_state)
      S_ARB: begin
        if (w_can_pop) begin
          w_pop_next        = w_grant;
          w_last_grant_next = w_grant_idx;
          w_state_next      = S_READ;
        end
      end
      S_READ: begin
        w_out_data_next  = w_read_word;
        w_out_valid_next = 1'b1;
        w_state_next     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          w_out_valid_next = 1'b0;
          if (w_can_pop) begin
            w_pop_next        = w_grant;
            w_last_grant_next = w_grant_idx;
            w_state_next      = S_READ;
          end else begin
            w_state_next = S_ARB;
          end
        end
      end
      default: w_state_next = S_ARB;
    endcase
    if (init) begin
      w_state_next      = S_ARB;
      w_out_valid_next  = 1'b0;
      w_pop_next        = '0;
      w_last_grant_next = 2'd3;
    end
  end

  assign pop       = r_pop;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign paused    = r_paused;
  assign halted    = r_halted;

endmodule

// File: tb/tb_qos_flow_arbiter.sv
// Directed self-checking bench for qos_flow_arbiter (default round-robin build).
module tb_qos_flow_arbiter;
  localparam int DW = 6;

  logic          CLK = 1'b0;
  logic          reset_L;
  logic          init;
  logic [3:0]    pause_stb, continue_stb, error_full, empty;
  logic [4*DW-1:0] fifo_data;
  logic [3:0]    pop;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    paused;
  logic          halted;

  int total = 0;
  int bad   = 0;

  localparam logic [DW-1:0] W [4] = '{6'h05, 6'h1A, 6'h2B, 6'h3C};

  assign fifo_data = {W[3], W[2], W[1], W[0]};

  always #5 CLK = ~CLK;

  qos_flow_arbiter #(.DATA_W(DW)) dut (
    .CLK          (CLK),
    .reset_L      (reset_L),
    .init         (init),
    .pause_stb    (pause_stb),
    .continue_stb (continue_stb),
    .error_full   (error_full),
    .empty        (empty),
    .fifo_data    (fifo_data),
    .pop          (pop),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .paused       (paused),
    .halted       (halted)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      $display("ok   %s obs=%0h exp=%0h", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One transfer with out_ready high: pop appears after the next edge, the word one edge later.
  task automatic xfer(input int idx, input string tag);
    tick();
    check({tag, ".pop"}, 32'(pop), 32'(4'b0001 << idx));
    tick();
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"}, 32'(out_data), 32'(W[idx]));
  endtask

  initial begin
    reset_L = 1'b0; init = 1'b0; pause_stb = '0; continue_stb = '0;
    error_full = '0; empty = 4'hF; out_ready = 1'b0;
    tick(); tick();
    check("rst.pop", 32'(pop), 32'd0);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.data", 32'(out_data), 32'd0);
    check("rst.paused", 32'(paused), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    reset_L = 1'b1;

    // Round-robin order
    empty = 4'b0000; out_ready = 1'b1;
    xfer(0, "rr0"); xfer(1, "rr1"); xfer(2, "rr2"); xfer(3, "rr3"); xfer(0, "rr4");

    // Pause FIFO1
    out_ready = 1'b0; pause_stb = 4'b0010;
    tick();
    check("pause.mask", 32'(paused), 32'b0010);
    check("pause.nopop", 32'(pop), 32'd0);
    pause_stb = '0; out_ready = 1'b1;
    xfer(2, "p2"); xfer(3, "p3"); xfer(0, "p0"); xfer(2, "p2b");

    // Continue FIFO1
    out_ready = 1'b0; continue_stb = 4'b0010;
    tick();
    check("cont.mask", 32'(paused), 32'd0);
    continue_stb = '0; out_ready = 1'b1;
    xfer(3, "c3"); xfer(0, "c0"); xfer(1, "c1");

    // Backpressure on word from FIFO1
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp%0d.valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d.data", i), 32'(out_data), 32'(W[1]));
      check($sformatf("bp%0d.pop", i), 32'(pop), 32'd0);
    end
    out_ready = 1'b1;
    xfer(2, "bp.rel");

    // Simultaneous pause/continue on FIFO2: pause wins
    out_ready = 1'b0; pause_stb = 4'b0100; continue_stb = 4'b0100;
    tick();
    check("both.mask", 32'(paused), 32'b0100);
    pause_stb = '0; continue_stb = '0; out_ready = 1'b1;
    xfer(3, "s3"); xfer(0, "s0"); xfer(1, "s1"); xfer(3, "s3b");
    out_ready = 1'b0; continue_stb = 4'b0100;
    tick();
    check("both.clear", 32'(paused), 32'd0);
    continue_stb = '0;

    // Error halt raised while word from FIFO3 is held
    error_full = 4'b1000;
    tick();
    check("err.halted", 32'(halted), 32'd1);
    check("err.hold.valid", 32'(out_valid), 32'd1);
    check("err.hold.data", 32'(out_data), 32'(W[3]));
    out_ready = 1'b1;
    tick();
    check("err.accept.valid", 32'(out_valid), 32'd0);
    check("err.accept.pop", 32'(pop), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("err%0d.pop", i), 32'(pop), 32'd0);
      check($sformatf("err%0d.halted", i), 32'(halted), 32'd1);
    end
    error_full = '0;
    tick();
    check("err.clr.halted", 32'(halted), 32'd0);
    check("err.clr.pop", 32'(pop), 32'd0);
    xfer(0, "err.resume");

    // Init while in S_READ also clears the paused mask
    pause_stb = 4'b1000;
    tick();
    check("init.pre.pop", 32'(pop), 32'b0010);
    check("init.pre.mask", 32'(paused), 32'b1000);
    pause_stb = '0; init = 1'b1;
    tick();
    check("init.valid", 32'(out_valid), 32'd0);
    check("init.mask", 32'(paused), 32'd0);
    check("init.pop", 32'(pop), 32'd0);
    init = 1'b0;
    xfer(0, "init.first");

    // Only FIFO0 non-empty, then all empty
    empty = 4'b1110;
    xfer(0, "one0"); xfer(0, "one0b");
    empty = 4'hF;
    tick();
    check("mt.valid", 32'(out_valid), 32'd0);
    check("mt.pop", 32'(pop), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mt%0d.pop", i), 32'(pop), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
